// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for fetch prediction.
// Execute-stage resolution updates the table and the branch/mispredict stats.
module riscv_branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_f,
   output logic            predict_taken_f,
   output logic [XLEN-1:0] predict_target_f,
   input  logic            update_valid_e,
   input  logic [XLEN-1:0] update_pc_e,
   input  logic            update_taken_e,
   input  logic [XLEN-1:0] update_target_e,
   input  logic            pred_taken_e,
   input  logic [XLEN-1:0] pred_target_e,
   output logic            mispredict_e,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [XLEN-1:0]    r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];
   logic [CNT_W-1:0]   r_branch_cnt;
   logic [CNT_W-1:0]   r_mis_cnt;

   logic [IDX_W-1:0] w_f_idx;
   logic [TAG_W-1:0] w_f_tag;
   logic             w_f_hit;
   logic [IDX_W-1:0] w_u_idx;
   logic [TAG_W-1:0] w_u_tag;
   logic             w_u_hit;
   logic             w_unused;

   // Byte offset within a word never selects an entry.
   assign w_unused = &{1'b0, pc_f[1:0], update_pc_e[1:0]};

   assign w_f_idx = pc_f[IDX_W+1:2];
   assign w_f_tag = pc_f[XLEN-1:IDX_W+2];
   assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

   assign predict_taken_f  = w_f_hit && r_ctr[w_f_idx][1];
   assign predict_target_f = predict_taken_f ? r_target[w_f_idx]
                                             : pc_f + XLEN'(4);

   assign w_u_idx = update_pc_e[IDX_W+1:2];
   assign w_u_tag = update_pc_e[XLEN-1:IDX_W+2];
   assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

   assign mispredict_e = update_valid_e &&
      ((update_taken_e != pred_taken_e) ||
       (update_taken_e && (update_target_e != pred_target_e)));

   assign branch_count     = r_branch_cnt;
   assign mispredict_count = r_mis_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'd1;
         end
      end else if (update_valid_e) begin
         if (w_u_hit) begin
            if (update_taken_e) begin
               r_target[w_u_idx] <= update_target_e;
               if (r_ctr[w_u_idx] != 2'd3)
                  r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
            end else if (r_ctr[w_u_idx] != 2'd0) begin
               r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
            end
         end else if (update_taken_e) begin
            // Miss on a taken branch replaces whatever lives at this index.
            r_valid[w_u_idx]  <= 1'b1;
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= update_target_e;
            r_ctr[w_u_idx]    <= 2'd2;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_branch_cnt <= '0;
         r_mis_cnt    <= '0;
      end else begin
         if (update_valid_e && (r_branch_cnt != {CNT_W{1'b1}}))
            r_branch_cnt <= r_branch_cnt + CNT_W'(1);
         if (mispredict_e && (r_mis_cnt != {CNT_W{1'b1}}))
            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed vector bench for riscv_branch_predictor.
// Second instance with CNT_W=2 shares inputs to exercise counter saturation.
module tb_riscv_branch_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] pc_f;
   logic        update_valid_e;
   logic [31:0] update_pc_e;
   logic        update_taken_e;
   logic [31:0] update_target_e;
   logic        pred_taken_e;
   logic [31:0] pred_target_e;

   logic        predict_taken_f;
   logic [31:0] predict_target_f;
   logic        mispredict_e;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   logic        s_taken;
   logic [31:0] s_target;
   logic        s_mis;
   logic [1:0]  s_bc;
   logic [1:0]  s_mc;

   int checks = 0;
   int errors = 0;

   riscv_branch_predictor dut (
      .clk(clk), .reset(reset), .pc_f(pc_f),
      .predict_taken_f(predict_taken_f),
      .predict_target_f(predict_target_f),
      .update_valid_e(update_valid_e), .update_pc_e(update_pc_e),
      .update_taken_e(update_taken_e),
      .update_target_e(update_target_e),
      .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
      .mispredict_e(mispredict_e), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   riscv_branch_predictor #(.CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .pc_f(pc_f),
      .predict_taken_f(s_taken), .predict_target_f(s_target),
      .update_valid_e(update_valid_e), .update_pc_e(update_pc_e),
      .update_taken_e(update_taken_e),
      .update_target_e(update_target_e),
      .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
      .mispredict_e(s_mis), .branch_count(s_bc),
      .mispredict_count(s_mc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utg;
      logic        pt;
      logic [31:0] ptg;
      logic        ept;
      logic [31:0] etg;
      logic        emis;
      logic [15:0] ebc;
      logic [15:0] emc;
   } vec_t;

   vec_t v [18];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      pc_f            = t.pc;
      update_valid_e  = t.uv;
      update_pc_e     = t.upc;
      update_taken_e  = t.ut;
      update_target_e = t.utg;
      pred_taken_e    = t.pt;
      pred_target_e   = t.ptg;
   endtask

   task automatic set_upd(input logic uv, input logic [31:0] upc,
                          input logic ut, input logic [31:0] utg,
                          input logic pt, input logic [31:0] ptg);
      update_valid_e  = uv;
      update_pc_e     = upc;
      update_taken_e  = ut;
      update_target_e = utg;
      pred_taken_e    = pt;
      pred_target_e   = ptg;
   endtask

   initial begin
      //        pc           uv   upc          ut   utg          pt   ptg           ept  etg          mis  bc mc
      v[0]  = '{32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 16'd0, 16'd0};
      v[1]  = '{32'h100,      1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 16'd0, 16'd0};
      v[2]  = '{32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 16'd1, 16'd1};
      v[3]  = '{32'h100,      1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 16'd1, 16'd1};
      v[4]  = '{32'h100,      1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 16'd2, 16'd2};
      v[5]  = '{32'h100,      1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 16'd3, 16'd2};
      v[6]  = '{32'h100,      1'b1, 32'h100, 1'b1, 32'h250, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 16'd4, 16'd2};
      v[7]  = '{32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 16'd5, 16'd3};
      v[8]  = '{32'h100,      1'b0, 32'h100, 1'b1, 32'h999, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 16'd5, 16'd3};
      v[9]  = '{32'h100,      1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144, 1'b0, 32'h104, 1'b1, 16'd5, 16'd3};
      v[10] = '{32'h100,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 16'd6, 16'd4};
      v[11] = '{32'h140,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 16'd6, 16'd4};
      v[12] = '{32'h140,      1'b1, 32'h140, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 16'd6, 16'd4};
      v[13] = '{32'h140,      1'b1, 32'h140, 1'b1, 32'h340, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 16'd7, 16'd4};
      v[14] = '{32'h140,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h340, 1'b0, 16'd8, 16'd5};
      v[15] = '{32'h104,      1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 32'h108, 1'b0, 32'h108, 1'b0, 16'd8, 16'd5};
      v[16] = '{32'h104,      1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h108, 1'b0, 16'd9, 16'd5};
      v[17] = '{32'hFFFFFFFC, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 16'd9, 16'd5};

      reset = 1'b0;
      pc_f  = 32'h100;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         drive(v[i]);
         #1;
         chk($sformatf("v%0d taken", i), {31'b0, predict_taken_f}, {31'b0, v[i].ept});
         chk($sformatf("v%0d target", i), predict_target_f, v[i].etg);
         chk($sformatf("v%0d mispredict", i), {31'b0, mispredict_e}, {31'b0, v[i].emis});
         chk($sformatf("v%0d branch_count", i), {16'b0, branch_count}, {16'b0, v[i].ebc});
         chk($sformatf("v%0d mispredict_count", i), {16'b0, mispredict_count}, {16'b0, v[i].emc});
         @(posedge clk);
         #1;
      end

      chk("sat branch_count", {30'b0, s_bc}, 32'd3);
      chk("sat mispredict_count", {30'b0, s_mc}, 32'd3);
      chk("wide mispredict_count", {16'b0, mispredict_count}, 32'd5);

      // Asynchronous reset between edges while 0x140 predicts taken.
      pc_f = 32'h140;
      #1;
      chk("pre-reset taken", {31'b0, predict_taken_f}, 32'd1);
      reset = 1'b0;
      #1;
      chk("async rst taken", {31'b0, predict_taken_f}, 32'd0);
      chk("async rst target", predict_target_f, 32'h144);
      chk("async rst branch_count", {16'b0, branch_count}, 32'd0);
      chk("async rst mispredict_count", {16'b0, mispredict_count}, 32'd0);

      // Update coinciding with held reset must write nothing.
      set_upd(1'b1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
      #1;
      chk("rst mispredict comb", {31'b0, mispredict_e}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst-win taken", {31'b0, predict_taken_f}, 32'd0);
      chk("rst-win target", predict_target_f, 32'h144);
      chk("rst-win branch_count", {16'b0, branch_count}, 32'd0);

      // First edge after release must take the pending update.
      @(posedge clk);
      #1;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("post-rel taken", {31'b0, predict_taken_f}, 32'd1);
      chk("post-rel target", predict_target_f, 32'h500);
      chk("post-rel branch_count", {16'b0, branch_count}, 32'd1);
      chk("post-rel mispredict_count", {16'b0, mispredict_count}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
